// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: lane-0 op codes, FSM state
// encodings and small op-classification helpers.
package mem_lsu_pkg;

   localparam int ALUOP_W = 5;

   typedef enum logic [ALUOP_W-1:0] {
      OP_NOP = 5'd0,
      OP_ALU = 5'd1,
      OP_LB  = 5'd8,
      OP_LBU = 5'd9,
      OP_LH  = 5'd10,
      OP_LHU = 5'd11,
      OP_LW  = 5'd12,
      OP_LWL = 5'd13,
      OP_LWR = 5'd14,
      OP_LL  = 5'd15,
      OP_SB  = 5'd16,
      OP_SH  = 5'd17,
      OP_SW  = 5'd18,
      OP_SWL = 5'd19,
      OP_SWR = 5'd20,
      OP_SC  = 5'd21
   } aluop_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } lsu_state_t;

   function automatic logic op_is_load(input aluop_t op);
      case (op)
         OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR, OP_LL: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic op_is_store(input aluop_t op);
      case (op)
         OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR, OP_SC: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // LWL/LWR/SWL/SWR are unaligned by design and never fault.
   function automatic logic op_misaligned(input aluop_t op, input logic [1:0] lo);
      case (op)
         OP_LH, OP_LHU, OP_SH:        return lo[0];
         OP_LW, OP_LL, OP_SW, OP_SC:  return (lo != 2'b00);
         default:                     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational data alignment: store byte enables and lane placement,
// load byte/half extraction with extension, and LWL/LWR register merge.
module mem_align
   import mem_lsu_pkg::*;
(
   input  logic [ALUOP_W-1:0] aluop,
   input  logic [1:0]         addr_lo,
   input  logic [31:0]        reg2,
   input  logic [31:0]        rdata_raw,
   output logic [3:0]         be,
   output logic [31:0]        st_data,
   output logic [31:0]        ld_data
);

   aluop_t      op;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign op = aluop_t'(aluop);

   // Store byte enables and data placed on the byte lanes the enables select.
   always_comb begin
      be      = 4'b0000;
      st_data = 32'h0;
      case (op)
         OP_SB: begin
            be      = 4'b0001 << addr_lo;
            st_data = {4{reg2[7:0]}};
         end
         OP_SH: begin
            be      = addr_lo[1] ? 4'b1100 : 4'b0011;
            st_data = {2{reg2[15:0]}};
         end
         OP_SW, OP_SC: begin
            be      = 4'b1111;
            st_data = reg2;
         end
         OP_SWL: begin
            case (addr_lo)
               2'd0:    begin be = 4'b0001; st_data = reg2 >> 24; end
               2'd1:    begin be = 4'b0011; st_data = reg2 >> 16; end
               2'd2:    begin be = 4'b0111; st_data = reg2 >> 8;  end
               default: begin be = 4'b1111; st_data = reg2;       end
            endcase
         end
         OP_SWR: begin
            case (addr_lo)
               2'd0:    begin be = 4'b1111; st_data = reg2;       end
               2'd1:    begin be = 4'b1110; st_data = reg2 << 8;  end
               2'd2:    begin be = 4'b1100; st_data = reg2 << 16; end
               default: begin be = 4'b1000; st_data = reg2 << 24; end
            endcase
         end
         OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR, OP_LL: begin
            be = 4'b1111;
         end
         default: begin
            be      = 4'b0000;
            st_data = 32'h0;
         end
      endcase
   end

   // Load result: extend the addressed byte/half, or merge for LWL/LWR.
   always_comb begin
      case (addr_lo)
         2'd0:    ld_byte = rdata_raw[7:0];
         2'd1:    ld_byte = rdata_raw[15:8];
         2'd2:    ld_byte = rdata_raw[23:16];
         default: ld_byte = rdata_raw[31:24];
      endcase
      ld_half = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
      ld_data = rdata_raw;
      case (op)
         OP_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU: ld_data = {24'h0, ld_byte};
         OP_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
         OP_LHU: ld_data = {16'h0, ld_half};
         OP_LWL: begin
            case (addr_lo)
               2'd0:    ld_data = {rdata_raw[7:0],  reg2[23:0]};
               2'd1:    ld_data = {rdata_raw[15:0], reg2[15:0]};
               2'd2:    ld_data = {rdata_raw[23:0], reg2[7:0]};
               default: ld_data = rdata_raw;
            endcase
         end
         OP_LWR: begin
            case (addr_lo)
               2'd0:    ld_data = rdata_raw;
               2'd1:    ld_data = {reg2[31:24], rdata_raw[31:8]};
               2'd2:    ld_data = {reg2[31:16], rdata_raw[31:16]};
               default: ld_data = {reg2[31:8],  rdata_raw[31:24]};
            endcase
         end
         default: ld_data = rdata_raw;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage load/store unit. Lane 0 may carry a memory op; all lanes are
// registered together into the WB bundle. The EX/MEM register is held by
// stall_o, so op, address and store data stay stable on the inputs for the
// whole bus transaction and are used directly.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no bus op outstanding; issues a request when a memory op arrives
// ST_REQ   | request presented, waiting for daddr_ok_i
// ST_WAIT  | address accepted, waiting for ddata_ok_i
// ST_DRAIN | op flushed after address accept; swallow its ddata_ok_i
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int LANES  = 2,
   parameter int ADDR_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  llbit_clr_i,
   input  logic                  valid_i,
   input  logic [ALUOP_W-1:0]    aluop_i,
   input  logic [ADDR_W-1:0]     mem_addr_i,
   input  logic [31:0]           reg2_i,
   input  logic [LANES*32-1:0]   inst_addr_i,
   input  logic [LANES*5-1:0]    waddr_i,
   input  logic [LANES-1:0]      we_i,
   input  logic [LANES*32-1:0]   wdata_i,
   input  logic [31:0]           hi_i,
   input  logic [31:0]           lo_i,
   input  logic                  whilo_i,
   output logic                  stall_o,
   output logic                  dreq_o,
   output logic                  dwr_o,
   output logic [3:0]            dbe_o,
   output logic [ADDR_W-1:0]     daddr_o,
   output logic [31:0]           dwdata_o,
   input  logic                  daddr_ok_i,
   input  logic                  ddata_ok_i,
   input  logic [31:0]           drdata_i,
   output logic                  wb_valid_o,
   output logic [LANES*32-1:0]   inst_addr_o,
   output logic [LANES*5-1:0]    waddr_o,
   output logic [LANES-1:0]      we_o,
   output logic [LANES*32-1:0]   wdata_o,
   output logic [31:0]           hi_o,
   output logic [31:0]           lo_o,
   output logic                  whilo_o,
   output logic                  adel_o,
   output logic                  ades_o,
   output logic [ADDR_W-1:0]     badvaddr_o
);

   aluop_t        op;
   lsu_state_t    state, state_nx;
   logic          llbit, ll_set;
   logic          is_ld, is_st, is_mem, misal, sc_fail, need_bus;
   logic          stall, dreq, wb_load;
   logic [3:0]    be;
   logic [31:0]   st_data, ld_data;
   logic [LANES-1:0]    we_nx;
   logic [LANES*32-1:0] wdata_nx;

   assign op       = aluop_t'(aluop_i);
   assign is_ld    = op_is_load(op);
   assign is_st    = op_is_store(op);
   assign is_mem   = is_ld | is_st;
   assign misal    = op_misaligned(op, mem_addr_i[1:0]);
   assign sc_fail  = (op == OP_SC) && !llbit;
   // Faulting ops and failed SCs finish in one cycle without the bus.
   assign need_bus = is_mem && !misal && !sc_fail;

   mem_align u_align (
      .aluop     (aluop_i),
      .addr_lo   (mem_addr_i[1:0]),
      .reg2      (reg2_i),
      .rdata_raw (drdata_i),
      .be        (be),
      .st_data   (st_data),
      .ld_data   (ld_data)
   );

   // State and LL link bit; a clear beats a same-cycle LL completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         llbit <= 1'b0;
      end else begin
         state <= state_nx;
         if (llbit_clr_i)
            llbit <= 1'b0;
         else if (ll_set)
            llbit <= 1'b1;
      end
   end

   // Next state, bus request, stall and writeback-capture decisions.
   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      dreq     = 1'b0;
      wb_load  = 1'b0;
      ll_set   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (valid_i && !flush) begin
               if (need_bus) begin
                  dreq  = 1'b1;
                  stall = 1'b1;
                  if (daddr_ok_i && ddata_ok_i) begin
                     stall   = 1'b0;
                     wb_load = 1'b1;
                     ll_set  = (op == OP_LL);
                  end else if (daddr_ok_i) begin
                     state_nx = ST_WAIT;
                  end else begin
                     state_nx = ST_REQ;
                  end
               end else begin
                  wb_load = 1'b1;
               end
            end
         end
         ST_REQ: begin
            // Request stays up under flush: an accept in this cycle must
            // still be drained.
            dreq  = 1'b1;
            stall = !flush;
            if (flush) begin
               state_nx = (daddr_ok_i && !ddata_ok_i) ? ST_DRAIN : ST_IDLE;
            end else if (daddr_ok_i && ddata_ok_i) begin
               stall    = 1'b0;
               wb_load  = 1'b1;
               ll_set   = (op == OP_LL);
               state_nx = ST_IDLE;
            end else if (daddr_ok_i) begin
               state_nx = ST_WAIT;
            end
         end
         ST_WAIT: begin
            stall = !flush;
            if (ddata_ok_i) begin
               state_nx = ST_IDLE;
               if (!flush) begin
                  stall   = 1'b0;
                  wb_load = 1'b1;
                  ll_set  = (op == OP_LL);
               end
            end else if (flush) begin
               state_nx = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (ddata_ok_i)
               state_nx = ST_IDLE;
            // Non-memory ops flow; a memory op is held until IDLE.
            if (valid_i && !flush) begin
               if (is_mem)
                  stall = 1'b1;
               else
                  wb_load = 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Lane-0 writeback overrides: load result, SC status, fault suppression.
   always_comb begin
      we_nx    = we_i;
      wdata_nx = wdata_i;
      if (misal)
         we_nx[0] = 1'b0;
      if (is_ld)
         wdata_nx[31:0] = ld_data;
      else if (op == OP_SC)
         wdata_nx[31:0] = {31'h0, !sc_fail};
   end

   assign stall_o  = stall && !rst;
   assign dreq_o   = dreq && !rst;
   assign dwr_o    = dreq_o && is_st;
   assign dbe_o    = dreq_o ? be : 4'b0000;
   assign daddr_o  = {mem_addr_i[ADDR_W-1:2], 2'b00};
   assign dwdata_o = st_data;

   // WB bundle register; write enables and faults drop when nothing retires.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid_o  <= 1'b0;
         inst_addr_o <= '0;
         waddr_o     <= '0;
         we_o        <= '0;
         wdata_o     <= '0;
         hi_o        <= '0;
         lo_o        <= '0;
         whilo_o     <= 1'b0;
         adel_o      <= 1'b0;
         ades_o      <= 1'b0;
         badvaddr_o  <= '0;
      end else begin
         wb_valid_o <= wb_load;
         if (wb_load) begin
            inst_addr_o <= inst_addr_i;
            waddr_o     <= waddr_i;
            we_o        <= we_nx;
            wdata_o     <= wdata_nx;
            hi_o        <= hi_i;
            lo_o        <= lo_i;
            whilo_o     <= whilo_i;
            adel_o      <= misal && is_ld;
            ades_o      <= misal && is_st;
            badvaddr_o  <= misal ? mem_addr_i : '0;
         end else begin
            we_o    <= '0;
            whilo_o <= 1'b0;
            adel_o  <= 1'b0;
            ades_o  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with hand-computed expected values.
module tb_mem_lsu;
   import mem_lsu_pkg::*;

   localparam int LANES  = 2;
   localparam int ADDR_W = 32;

   logic                  clk = 1'b0;
   logic                  rst, flush, llbit_clr_i, valid_i;
   logic [ALUOP_W-1:0]    aluop_i;
   logic [ADDR_W-1:0]     mem_addr_i;
   logic [31:0]           reg2_i;
   logic [LANES*32-1:0]   inst_addr_i;
   logic [LANES*5-1:0]    waddr_i;
   logic [LANES-1:0]      we_i;
   logic [LANES*32-1:0]   wdata_i;
   logic [31:0]           hi_i, lo_i;
   logic                  whilo_i;
   logic                  stall_o, dreq_o, dwr_o;
   logic [3:0]            dbe_o;
   logic [ADDR_W-1:0]     daddr_o;
   logic [31:0]           dwdata_o;
   logic                  daddr_ok_i, ddata_ok_i;
   logic [31:0]           drdata_i;
   logic                  wb_valid_o;
   logic [LANES*32-1:0]   inst_addr_o;
   logic [LANES*5-1:0]    waddr_o;
   logic [LANES-1:0]      we_o;
   logic [LANES*32-1:0]   wdata_o;
   logic [31:0]           hi_o, lo_o;
   logic                  whilo_o, adel_o, ades_o;
   logic [ADDR_W-1:0]     badvaddr_o;

   int n_vec = 0;
   int n_err = 0;
   int stall_cnt;

   mem_lsu #(.LANES(LANES), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .llbit_clr_i(llbit_clr_i),
      .valid_i(valid_i), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
      .reg2_i(reg2_i), .inst_addr_i(inst_addr_i), .waddr_i(waddr_i),
      .we_i(we_i), .wdata_i(wdata_i), .hi_i(hi_i), .lo_i(lo_i),
      .whilo_i(whilo_i), .stall_o(stall_o), .dreq_o(dreq_o), .dwr_o(dwr_o),
      .dbe_o(dbe_o), .daddr_o(daddr_o), .dwdata_o(dwdata_o),
      .daddr_ok_i(daddr_ok_i), .ddata_ok_i(ddata_ok_i), .drdata_i(drdata_i),
      .wb_valid_o(wb_valid_o), .inst_addr_o(inst_addr_o), .waddr_o(waddr_o),
      .we_o(we_o), .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o),
      .whilo_o(whilo_o), .adel_o(adel_o), .ades_o(ades_o),
      .badvaddr_o(badvaddr_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic present(input aluop_t op, input logic [31:0] addr, input logic [31:0] r2);
      valid_i    = 1'b1;
      aluop_i    = op;
      mem_addr_i = addr;
      reg2_i     = r2;
      #1;
   endtask

   // Address and data accepted in the current cycle, then the op is removed.
   task automatic finish_fast(input logic [31:0] rd);
      daddr_ok_i = 1'b1;
      ddata_ok_i = 1'b1;
      drdata_i   = rd;
      tick();
      valid_i    = 1'b0;
      daddr_ok_i = 1'b0;
      ddata_ok_i = 1'b0;
   endtask

   task automatic ld_case(input string tag, input aluop_t op, input logic [31:0] addr,
                          input logic [31:0] r2, input logic [31:0] rd, input logic [31:0] exp);
      present(op, addr, r2);
      check({tag, "_dreq"}, dreq_o, 1'b1);
      finish_fast(rd);
      check({tag, "_wdata"}, wdata_o[31:0], exp);
   endtask

   task automatic st_case(input string tag, input aluop_t op, input logic [31:0] addr,
                          input logic [31:0] r2, input logic [3:0] be, input logic [31:0] d);
      present(op, addr, r2);
      check({tag, "_dbe"}, dbe_o, be);
      check({tag, "_dwdata"}, dwdata_o, d);
      check({tag, "_dwr"}, dwr_o, 1'b1);
      finish_fast(32'h0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; llbit_clr_i = 1'b0; valid_i = 1'b0;
      aluop_i = OP_NOP; mem_addr_i = '0; reg2_i = '0;
      inst_addr_i = {32'hBFC0_0014, 32'hBFC0_0010};
      waddr_i = {5'd9, 5'd5};
      we_i = 2'b11;
      wdata_i = {32'hCAFE_0001, 32'h0000_AAAA};
      hi_i = 32'h1111_2222; lo_i = 32'h3333_4444; whilo_i = 1'b1;
      daddr_ok_i = 1'b0; ddata_ok_i = 1'b0; drdata_i = '0;
      tick(); tick();
      check("rst_wb_valid", wb_valid_o, 1'b0);
      check("rst_we", we_o, 2'b00);
      check("rst_stall", stall_o, 1'b0);
      check("rst_dreq", dreq_o, 1'b0);
      check("rst_wdata", wdata_o, 64'h0);
      check("rst_badvaddr", badvaddr_o, 32'h0);
      rst = 1'b0;

      // Non-memory op, latency 1.
      present(OP_ALU, 32'h0, 32'h0);
      check("alu_stall", stall_o, 1'b0);
      check("alu_dreq", dreq_o, 1'b0);
      tick();
      valid_i = 1'b0;
      check("alu_wb_valid", wb_valid_o, 1'b1);
      check("alu_wdata", wdata_o, {32'hCAFE_0001, 32'h0000_AAAA});
      check("alu_waddr", waddr_o, {5'd9, 5'd5});
      check("alu_hilo", {hi_o, lo_o}, {32'h1111_2222, 32'h3333_4444});
      check("alu_whilo", whilo_o, 1'b1);
      whilo_i = 1'b0;
      tick();
      check("alu_wb_drop", wb_valid_o, 1'b0);

      // LB with address accept on first REQ cycle, data two cycles later.
      stall_cnt = 0;
      present(OP_LB, 32'h1003, 32'h0);
      check("lb_dreq0", dreq_o, 1'b1);
      check("lb_daddr", daddr_o, 32'h1000);
      stall_cnt += int'(stall_o);
      tick();
      daddr_ok_i = 1'b1; #1;
      check("lb_dreq_req", dreq_o, 1'b1);
      stall_cnt += int'(stall_o);
      tick();
      daddr_ok_i = 1'b0; #1;
      check("lb_dreq_wait", dreq_o, 1'b0);
      stall_cnt += int'(stall_o);
      tick();
      ddata_ok_i = 1'b1; drdata_i = 32'h80FF_0000; #1;
      check("lb_stall_done", stall_o, 1'b0);
      stall_cnt += int'(stall_o);
      tick();
      ddata_ok_i = 1'b0; valid_i = 1'b0;
      check("lb_wb_valid", wb_valid_o, 1'b1);
      check("lb_wdata0", wdata_o[31:0], 32'hFFFF_FF80);
      check("lb_wdata1", wdata_o[63:32], 32'hCAFE_0001);
      check("lb_stall_cycles", stall_cnt, 3);

      // SWR: request held one cycle, then address+data accepted together.
      present(OP_SWR, 32'h2001, 32'h1122_3344);
      check("swr_dbe", dbe_o, 4'b1110);
      check("swr_dwdata", dwdata_o, 32'h2233_4400);
      check("swr_dwr", dwr_o, 1'b1);
      tick();
      daddr_ok_i = 1'b1; ddata_ok_i = 1'b1; #1;
      check("swr_req_stall", stall_o, 1'b0);
      tick();
      valid_i = 1'b0; daddr_ok_i = 1'b0; ddata_ok_i = 1'b0;
      check("swr_wb_valid", wb_valid_o, 1'b1);

      st_case("sb",  OP_SB,  32'h2002, 32'h0000_00AB, 4'b0100, 32'hABAB_ABAB);
      st_case("sh",  OP_SH,  32'h2002, 32'h0000_1234, 4'b1100, 32'h1234_1234);
      st_case("swl", OP_SWL, 32'h2001, 32'h1122_3344, 4'b0011, 32'h0000_1122);
      st_case("sw",  OP_SW,  32'h2004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

      ld_case("lh",  OP_LH,  32'h0012, 32'h0, 32'h8001_7F00, 32'hFFFF_8001);
      ld_case("lhu", OP_LHU, 32'h0012, 32'h0, 32'h8001_7F00, 32'h0000_8001);
      ld_case("lbu", OP_LBU, 32'h0001, 32'h0, 32'h0000_F200, 32'h0000_00F2);
      ld_case("lwl", OP_LWL, 32'h0000, 32'h1122_3344, 32'hAABB_CCDD, 32'hDD22_3344);
      ld_case("lwr", OP_LWR, 32'h0001, 32'h1122_3344, 32'hAABB_CCDD, 32'h11AA_BBCC);
      ld_case("lw",  OP_LW,  32'h0008, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

      // Misaligned accesses.
      present(OP_LW, 32'h3002, 32'h0);
      check("adel_dreq", dreq_o, 1'b0);
      check("adel_stall", stall_o, 1'b0);
      tick();
      valid_i = 1'b0;
      check("adel_flag", adel_o, 1'b1);
      check("adel_ades", ades_o, 1'b0);
      check("adel_badvaddr", badvaddr_o, 32'h3002);
      check("adel_we", we_o, 2'b10);
      check("adel_wb_valid", wb_valid_o, 1'b1);
      present(OP_SH, 32'h3001, 32'h0);
      check("ades_dreq", dreq_o, 1'b0);
      tick();
      valid_i = 1'b0;
      check("ades_flag", ades_o, 1'b1);
      check("ades_badvaddr", badvaddr_o, 32'h3001);

      // LL then SC succeeds.
      ld_case("ll", OP_LL, 32'h0040, 32'h0, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
      present(OP_SC, 32'h0040, 32'h0000_0055);
      check("sc_ok_dreq", dreq_o, 1'b1);
      check("sc_ok_dbe", dbe_o, 4'b1111);
      check("sc_ok_dwdata", dwdata_o, 32'h0000_0055);
      finish_fast(32'h0);
      check("sc_ok_wdata", wdata_o[31:0], 32'h1);

      // LL, clear, SC fails without bus.
      ld_case("ll2", OP_LL, 32'h0040, 32'h0, 32'h0, 32'h0);
      llbit_clr_i = 1'b1;
      tick();
      llbit_clr_i = 1'b0;
      present(OP_SC, 32'h0040, 32'h0000_0055);
      check("sc_fail_dreq", dreq_o, 1'b0);
      check("sc_fail_stall", stall_o, 1'b0);
      tick();
      valid_i = 1'b0;
      check("sc_fail_wdata", wdata_o[31:0], 32'h0);
      check("sc_fail_we", we_o[0], 1'b1);

      // Clear arriving with the LL completion wins.
      present(OP_LL, 32'h0040, 32'h0);
      llbit_clr_i = 1'b1;
      finish_fast(32'h0);
      llbit_clr_i = 1'b0;
      present(OP_SC, 32'h0040, 32'h0);
      check("clr_wins_dreq", dreq_o, 1'b0);
      tick();
      valid_i = 1'b0;

      // Flush in IDLE drops the op.
      flush = 1'b1;
      present(OP_LW, 32'h0080, 32'h0);
      check("flush_idle_dreq", dreq_o, 1'b0);
      tick();
      flush = 1'b0; valid_i = 1'b0;
      check("flush_idle_wb", wb_valid_o, 1'b0);

      // Flush in REQ before address accept.
      present(OP_LW, 32'h0080, 32'h0);
      tick();
      flush = 1'b1; #1;
      check("flush_req_stall", stall_o, 1'b0);
      tick();
      flush = 1'b0; valid_i = 1'b0; #1;
      check("flush_req_wb", wb_valid_o, 1'b0);
      check("flush_req_dreq", dreq_o, 1'b0);

      // Flush in WAIT, data three cycles later, next LW waits for it.
      present(OP_LW, 32'h0050, 32'h0);
      tick();
      daddr_ok_i = 1'b1;
      tick();
      daddr_ok_i = 1'b0; flush = 1'b1; #1;
      check("drain_flush_stall", stall_o, 1'b0);
      tick();
      flush = 1'b0;
      present(OP_LW, 32'h0060, 32'h0);
      check("drain_hold_stall", stall_o, 1'b1);
      check("drain_hold_dreq", dreq_o, 1'b0);
      check("drain_wb0", wb_valid_o, 1'b0);
      tick();
      check("drain_wb1", wb_valid_o, 1'b0);
      tick();
      ddata_ok_i = 1'b1; drdata_i = 32'h1111_1111; #1;
      check("drain_swallow_dreq", dreq_o, 1'b0);
      check("drain_swallow_stall", stall_o, 1'b1);
      tick();
      ddata_ok_i = 1'b0; #1;
      check("drain_exit_wb", wb_valid_o, 1'b0);
      check("drain_next_dreq", dreq_o, 1'b1);
      check("drain_next_daddr", daddr_o, 32'h0060);
      finish_fast(32'h1234_5678);
      check("drain_next_wdata", wdata_o[31:0], 32'h1234_5678);
      check("drain_next_wb", wb_valid_o, 1'b1);

      // Reset mid-transaction.
      whilo_i = 1'b1;
      present(OP_LW, 32'h0070, 32'h0);
      tick();
      rst = 1'b1; valid_i = 1'b0;
      tick();
      rst = 1'b0; #1;
      check("rst_req_dreq", dreq_o, 1'b0);
      check("rst_req_stall", stall_o, 1'b0);
      check("rst_req_wb", wb_valid_o, 1'b0);
      check("rst_req_wdata", wdata_o, 64'h0);
      check("rst_req_waddr", waddr_o, 10'h0);
      check("rst_req_hilo", {hi_o, lo_o}, 64'h0);
      present(OP_LW, 32'h0074, 32'h0);
      check("rst_idle_dreq", dreq_o, 1'b1);
      finish_fast(32'h0BAD_F00D);
      check("rst_idle_wdata", wdata_o[31:0], 32'h0BAD_F00D);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter LANES, default 2, number of issue lanes passed from EX to WB; lane 0 alone may carry a memory op.
REQ-002 Parameter ADDR_W, default 32, data-bus address width; data width fixed at 32.
REQ-003 Ports: clk  in  1  rising-edge clock.
REQ-004 Ports: rst  in  1  reset rst, synchronous, active-high.
REQ-005 Ports: flush  in  1  exception flush; llbit_clr_i  in  1  clears LL link bit (ERET).
REQ-006 Ports: valid_i  in  1; aluop_i  in  AluOp width  lane-0 op; mem_addr_i  in  ADDR_W; reg2_i  in  32  store data / LWL-LWR merge value.
REQ-007 Ports: inst_addr_i  in  LANES*32; waddr_i  in  LANES*5; we_i  in  LANES; wdata_i  in  LANES*32; hi_i, lo_i  in  32; whilo_i  in  1.
REQ-008 Ports: stall_o  out  1  holds EX/MEM register while high.
REQ-009 Ports: dreq_o, dwr_o  out  1; dbe_o  out  4; daddr_o  out  ADDR_W (bits[1:0]=0); dwdata_o  out  32; daddr_ok_i, ddata_ok_i  in  1; drdata_i  in  32.
REQ-010 Ports: wb_valid_o  out  1; inst_addr_o, waddr_o, we_o, wdata_o  out  per-lane widths; hi_o, lo_o  out  32; whilo_o  out  1 -- all registered.
REQ-011 Ports: adel_o, ades_o  out  1; badvaddr_o  out  ADDR_W  registered with the bundle.

Function
REQ-012 FSM states IDLE, REQ, WAIT, DRAIN; reset state IDLE.
REQ-013 Non-memory op, valid_i=1, IDLE: bundle registered to WB next cycle, stall_o=0 (latency 1).
REQ-014 Memory op in IDLE: stall_o=1 combinationally, dreq_o=1, go REQ; REQ holds dreq_o and address stable until daddr_ok_i, then WAIT.
REQ-015 daddr_ok_i and ddata_ok_i same cycle in REQ: complete directly, return IDLE.
REQ-016 WAIT: on ddata_ok_i register bundle with load result, stall_o=0 that cycle, return IDLE.
REQ-017 Loads: LB/LBU/LH/LHU sign/zero extend byte/half at addr[1:0]; LW, LL whole word; LWL/LWR merge drdata_i with reg2_i per MIPS little-endian (LWL 00 -> {d[7:0],r[23:0]}; LWR 01 -> {r[31:24],d[31:8]}).
REQ-018 Stores: SB dbe=0001<<addr[1:0], byte replicated; SH 0011/1100, half replicated; SW 1111.
REQ-019 SWL dbe by addr 00/01/10/11 = 0001/0011/0111/1111, data rs>>24/16/8/0; SWR = 1111/1110/1100/1000, data rs<<0/8/16/24.
REQ-020 Misaligned LH/LHU/SH (addr[0]=1) or LW/LL/SW/SC (addr[1:0]!=0): no dreq, 1-cycle pass, adel_o/ades_o=1, badvaddr_o=mem_addr_i, we_o[0]=0.
REQ-021 LL sets llbit at completion; SC with llbit=1 stores and writes 1; llbit=0 issues no request, writes 0, latency 1.
REQ-022 llbit cleared by llbit_clr_i or rst; clear and LL-set same cycle: clear wins.
REQ-023 flush in IDLE or REQ before daddr_ok_i: drop request, go IDLE, wb_valid_o=0 next cycle.
REQ-024 flush in WAIT or in REQ with daddr_ok_i: go DRAIN, swallow ddata_ok_i with no writeback, then IDLE; stall_o=0 in DRAIN, new memory ops wait in IDLE until DRAIN exits.
REQ-025 Lanes >=1 ride with lane 0 unchanged; discarded together on flush.

Reset
REQ-026 On rst: state IDLE, llbit=0, dreq_o=0, stall_o=0, wb_valid_o=0, we_o=0, whilo_o=0, waddr_o=0, wdata_o/hi_o/lo_o/badvaddr_o=0, adel_o/ades_o=0; rst overrides flush and mid-transaction state.

Structure
REQ-027 AluOp codes and FSM state encodings belong in the shared defines file.
REQ-028 Combinational sub-module mem_align: load extract/merge and store byte-enable/data generation.

Verification
REQ-029 LB addr 0x1003, drdata 0x80FF0000, ddata_ok 2 cycles after addr_ok -> wdata_o[0]=0xFFFFFF80, stall_o high 3 cycles.
REQ-030 SWR addr 0x2001, reg2 0x11223344 -> dbe_o=1110, dwdata_o=0x22334400, dwr_o=1.
REQ-031 LW addr 0x3002 -> no dreq, adel_o=1, badvaddr_o=0x3002, we_o[0]=0.
REQ-032 LL 0x40 then SC 0x40 -> SC stores, wdata=1; LL, llbit_clr_i, SC -> no dreq, wdata=0.
REQ-033 flush in WAIT, ddata_ok 3 cycles later -> DRAIN, no wb_valid_o, next LW issues after ddata_ok.
REQ-034 rst asserted in REQ -> next cycle dreq_o=0, IDLE, all outputs zero.
